uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel receive stage that directly feeds the main controller.
- Samples the synchronized RX line with a 16x oversampling tick and deframes start/data/parity/stop bits.
- Each completed frame is delivered as one data byte plus a one-cycle valid strobe.
- Reports frame, parity and overrun errors on the same strobe, so the main controller and the RX FIFO consume one event per frame.

Parameters:
- OVERSAMPLE, 16, ticks per bit period; must be a power of two ≥ 8.
- SAMPLE_POINT, 7, tick index (0-based) at which a bit is sampled; nominally OVERSAMPLE/2-1.

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  asynchronous active-low reset
- ov_tick_i  input  1  1-cycle pulse at OVERSAMPLE × baud rate, from baud generator
- rx_i  input  1  raw serial line, idle high, asynchronous to clk_i
- rx_enable_i  input  1  when low, start bits are ignored; a frame in progress completes
- config_i  input  6  uart_config_s: data_width[1:0], parity_mode[1:0], stop_bits[1:0]
- rx_fifo_full_i  input  1  RX FIFO full flag
- data_rx_o  output  8  received data, right-aligned, unused MSBs zero
- rx_done_o  output  1  1-cycle strobe: frame complete; data and error flags valid
- rx_fifo_write_o  output  1  write strobe to RX FIFO (rx_done_o & ~rx_fifo_full_i)
- frame_error_o  output  1  valid with rx_done_o: a stop bit sampled 0
- parity_error_o  output  1  valid with rx_done_o: parity mismatch
- overrun_error_o  output  1  valid with rx_done_o: FIFO was full, byte dropped
- busy_o  output  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0; FSM to IDLE; tick and bit counters 0; synchronizer flops reset to 1 (line idle).
- rx_i passes through a 2-flop synchronizer. A falling edge is detected as synchronized prev=1, cur=0.
- Config field encodings:
  - data_width: 00=5, 01=6, 10=7, 11=8 bits.
  - parity_mode: 00=even, 01=odd, 1x=none.
  - stop_bits: 00=1, 01=2, 1x=2.
- config_i is latched on entry to START. Config changes mid-frame have no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE.
  - IDLE -> START on a falling edge while rx_enable_i=1; tick counter cleared.
  - START: count ov_tick_i. At tick SAMPLE_POINT, a sample of 1 is a glitch -> IDLE with no output. A sample of 0 continues; at tick OVERSAMPLE-1 -> DATA.
  - DATA: one bit per OVERSAMPLE ticks, sampled at SAMPLE_POINT, shifted in LSB first. After data_width bits -> PARITY if parity enabled, else STOP.
  - PARITY: sample one bit. Error when (XOR of data bits ^ parity bit) ≠ parity_mode[0].
  - STOP: sample 1 or 2 stop bits at SAMPLE_POINT. Any 0 sets frame_error. The transition to DONE happens on the sampling tick of the last stop bit, not at the end of the bit period, so back-to-back frames resync.
  - DONE: a single cycle. rx_done_o=1; data/error outputs updated. rx_fifo_write_o=~rx_fifo_full_i; overrun_error_o=rx_fifo_full_i. Then -> IDLE.
- Latency: rx_done_o asserts exactly 1 clk after the ov_tick_i that sampled the last stop bit.
- data_rx_o and error outputs hold their value until the next DONE. Error flags are cleared at START entry.
- A frame error with the line held low (break) returns to IDLE. A new start is recognized only after the line returns high (edge detection requires prev=1).
- Simultaneous rx_enable_i deassertion and falling edge: no start.
- Async reset mid-frame: frame discarded, no strobe, all outputs 0 immediately.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined: each bit value is the 2-of-3 majority of samples at ticks SAMPLE_POINT-1, SAMPLE_POINT, SAMPLE_POINT+1. The bit decision and state advance occur at SAMPLE_POINT+1; rx_done_o latency grows by 1 ov_tick period.
- Undefined: single sample at SAMPLE_POINT.
- Port list is identical in both builds.

Decomposition:
- UART_pkg holds:
  - uart_config_s, with data_width_e, parity_mode_e and stop_bits_e enums using the encodings above;
  - rx_state_e;
  - STD_CONFIG = {8 bits, even, 1 stop}.
- Sub-module: uart_rx_sampler (synchronizer, edge detect, optional majority vote). The FSM stays in uart_receiver.

Test Plan:
- STD_CONFIG, frame 0x5A, even parity bit 0, 1 stop -> rx_done_o once; data_rx_o=0x5A; all errors 0; rx_fifo_write_o=1.
- 5-bit, odd parity, 2 stops, data 0x13 with wrong parity bit 1 -> data_rx_o=0x13; parity_error_o=1; frame_error_o=0.
- 8-bit, no parity, stop bit driven 0 for data 0xFF -> data_rx_o=0xFF; frame_error_o=1; after the line returns high, next frame 0x01 is received cleanly.
- rx_i low pulse of 4 ticks while idle -> no rx_done_o; busy_o returns to 0 at tick SAMPLE_POINT.
- rx_fifo_full_i=1 during frame 0xA5 -> rx_done_o=1; overrun_error_o=1; rx_fifo_write_o=0; data_rx_o=0xA5.
- rst_n_i pulsed low during DATA bit 3 -> outputs 0 immediately; no strobe; next full frame 0x3C received correctly.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared types for the UART receive path: frame configuration fields, FSM states
// and small parity/vote helpers used by uart_receiver and uart_rx_sampler.
package uart_receiver_pkg;

    typedef enum logic [1:0] {
        DW_5 = 2'b00,
        DW_6 = 2'b01,
        DW_7 = 2'b10,
        DW_8 = 2'b11
    } data_width_e;

    typedef enum logic [1:0] {
        PAR_EVEN   = 2'b00,
        PAR_ODD    = 2'b01,
        PAR_NONE   = 2'b10,
        PAR_NONE_X = 2'b11
    } parity_mode_e;

    typedef enum logic [1:0] {
        STOP_1   = 2'b00,
        STOP_2   = 2'b01,
        STOP_2_X = 2'b10,
        STOP_2_Y = 2'b11
    } stop_bits_e;

    typedef struct packed {
        data_width_e  data_width;
        parity_mode_e parity_mode;
        stop_bits_e   stop_bits;
    } uart_config_s;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_DONE   = 3'd5
    } rx_state_e;

    localparam uart_config_s STD_CONFIG = '{data_width: DW_8, parity_mode: PAR_EVEN, stop_bits: STOP_1};

    // Index of the final data bit: width code 0..3 maps to 5..8 bits.
    function automatic logic [2:0] last_data_idx(input logic [1:0] dw);
        return 3'd4 + {1'b0, dw};
    endfunction

    function automatic logic parity_enabled(input logic [1:0] pm);
        return ~pm[1];
    endfunction

    function automatic logic odd_parity(input logic [1:0] pm);
        return pm[0];
    endfunction

    function automatic logic two_stops(input logic [1:0] sb);
        return (sb != 2'b00);
    endfunction

    function automatic logic calc_parity(input logic [7:0] d);
        return ^d;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line conditioning: 2-flop synchronizer, falling-edge detect and bit value.
// Build option: UART_RX_MAJORITY_VOTE_EN adds a 3-sample majority vote across ov ticks.
module uart_rx_sampler
    import uart_receiver_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
`ifdef UART_RX_MAJORITY_VOTE_EN
    input  logic ov_tick_i,
`endif
    input  logic rx_i,
    output logic fall_o,
    output logic bit_o
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;

    // Synchronizer and edge-history next values
    always_comb begin
        sync1_d = rx_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Line flops reset to idle-high so reset never fakes a start edge
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign fall_o = prev_q & ~sync2_q;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q, hist_d;

    // Keep the two previous tick samples so the vote completes one tick later
    always_comb begin
        if (ov_tick_i) begin
            hist_d = {hist_q[0], sync2_q};
        end else begin
            hist_d = hist_q;
        end
    end

    // Sample history register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign bit_o = maj3(hist_q[1], hist_q[0], sync2_q);
`else
    assign bit_o = sync2_q;
`endif

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART deframer delivering one byte plus error flags per frame.
// Build option: UART_RX_MAJORITY_VOTE_EN decides each bit by 2-of-3 vote one tick later.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int OVERSAMPLE   = 16,
    parameter int SAMPLE_POINT = 7
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ov_tick_i,
    input  logic       rx_i,
    input  logic       rx_enable_i,
    input  logic [5:0] config_i,
    input  logic       rx_fifo_full_i,
    output logic [7:0] data_rx_o,
    output logic       rx_done_o,
    output logic       rx_fifo_write_o,
    output logic       frame_error_o,
    output logic       parity_error_o,
    output logic       overrun_error_o,
    output logic       busy_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int DECIDE_PT = SAMPLE_POINT + 1;
`else
    localparam int DECIDE_PT = SAMPLE_POINT;
`endif
    localparam logic [CNT_W-1:0] DECIDE_TICK = CNT_W'(DECIDE_PT);
    localparam logic [CNT_W-1:0] LAST_TICK   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] TICK_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    rx_state_e    state_q, state_d;
    logic [CNT_W-1:0] tick_q, tick_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic         stop_cnt_q, stop_cnt_d;
    uart_config_s cfg_q, cfg_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_err_q, par_err_d;
    logic         frm_err_q, frm_err_d;
    logic [7:0]   data_q, data_d;
    logic         done_q, done_d;
    logic         fifo_wr_q, fifo_wr_d;
    logic         frame_err_q, frame_err_d;
    logic         parity_err_q, parity_err_d;
    logic         overrun_q, overrun_d;
    logic         busy_q, busy_d;
    logic         fall_s;
    logic         bit_s;

    uart_rx_sampler u_sampler (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
`ifdef UART_RX_MAJORITY_VOTE_EN
        .ov_tick_i (ov_tick_i),
`endif
        .rx_i    (rx_i),
        .fall_o  (fall_s),
        .bit_o   (bit_s)
    );

    // Deframing FSM: next state, working registers and registered outputs
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        cfg_d        = cfg_q;
        shift_d      = shift_q;
        par_err_d    = par_err_q;
        frm_err_d    = frm_err_q;
        data_d       = data_q;
        done_d       = 1'b0;
        fifo_wr_d    = 1'b0;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        overrun_d    = overrun_q;

        case (state_q)
            RX_IDLE: begin
                if (fall_s && rx_enable_i) begin
                    state_d    = RX_START;
                    tick_d     = '0;
                    bit_cnt_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                    cfg_d      = uart_config_s'(config_i);
                    shift_d    = 8'h00;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (ov_tick_i) begin
                    tick_d = tick_q + TICK_ONE;
                    if ((tick_q == DECIDE_TICK) && bit_s) begin
                        state_d = RX_IDLE;
                    end else if (tick_q == LAST_TICK) begin
                        state_d = RX_DATA;
                    end else begin
                        state_d = RX_START;
                    end
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (ov_tick_i) begin
                    tick_d = tick_q + TICK_ONE;
                    if (tick_q == DECIDE_TICK) begin
                        shift_d[bit_cnt_q] = bit_s;
                    end else if (tick_q == LAST_TICK) begin
                        if (bit_cnt_q == last_data_idx(cfg_q.data_width)) begin
                            if (parity_enabled(cfg_q.parity_mode)) begin
                                state_d = RX_PARITY;
                            end else begin
                                state_d = RX_STOP;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (ov_tick_i) begin
                    tick_d = tick_q + TICK_ONE;
                    if (tick_q == DECIDE_TICK) begin
                        par_err_d = ((calc_parity(shift_q) ^ bit_s) != odd_parity(cfg_q.parity_mode));
                    end else if (tick_q == LAST_TICK) begin
                        state_d = RX_STOP;
                    end else begin
                        state_d = RX_PARITY;
                    end
                end else begin
                    state_d = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (ov_tick_i) begin
                    tick_d = tick_q + TICK_ONE;
                    if (tick_q == DECIDE_TICK) begin
                        frm_err_d = frm_err_q | ~bit_s;
                        // Finish at the last stop sample, mid-bit, so the next start edge is caught
                        if (stop_cnt_q == two_stops(cfg_q.stop_bits)) begin
                            state_d      = RX_DONE;
                            done_d       = 1'b1;
                            data_d       = shift_q;
                            parity_err_d = par_err_q;
                            frame_err_d  = frm_err_q | ~bit_s;
                            fifo_wr_d    = ~rx_fifo_full_i;
                            overrun_d    = rx_fifo_full_i;
                        end else begin
                            state_d = RX_STOP;
                        end
                    end else if (tick_q == LAST_TICK) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = RX_STOP;
                    end
                end else begin
                    state_d = RX_STOP;
                end
            end
            RX_DONE: begin
                state_d = RX_IDLE;
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        busy_d = (state_d != RX_IDLE);
    end

    // State, counters and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= RX_IDLE;
            tick_q       <= '0;
            bit_cnt_q    <= 3'd0;
            stop_cnt_q   <= 1'b0;
            cfg_q        <= STD_CONFIG;
            shift_q      <= 8'h00;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            data_q       <= 8'h00;
            done_q       <= 1'b0;
            fifo_wr_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            cfg_q        <= cfg_d;
            shift_q      <= shift_d;
            par_err_q    <= par_err_d;
            frm_err_q    <= frm_err_d;
            data_q       <= data_d;
            done_q       <= done_d;
            fifo_wr_q    <= fifo_wr_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign data_rx_o       = data_q;
    assign rx_done_o       = done_q;
    assign rx_fifo_write_o = fifo_wr_q;
    assign frame_error_o   = frame_err_q;
    assign parity_error_o  = parity_err_q;
    assign overrun_error_o = overrun_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frame-level reference model plus directed frames.
// Honours UART_RX_MAJORITY_VOTE_EN for the expected bit-decision tick.
module tb_uart_receiver;
    import uart_receiver_pkg::*;

    localparam int OS = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int DECIDE = 8;
`else
    localparam int DECIDE = 7;
`endif

    logic       clk = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       ov_tick_i = 1'b0;
    logic       rx_i = 1'b1;
    logic       rx_enable_i = 1'b1;
    logic [5:0] config_i = 6'b000000;
    logic       rx_fifo_full_i = 1'b0;
    logic [7:0] data_rx_o;
    logic       rx_done_o, rx_fifo_write_o, frame_error_o, parity_error_o, overrun_error_o, busy_o;

    uart_receiver dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n_i),
        .ov_tick_i       (ov_tick_i),
        .rx_i            (rx_i),
        .rx_enable_i     (rx_enable_i),
        .config_i        (config_i),
        .rx_fifo_full_i  (rx_fifo_full_i),
        .data_rx_o       (data_rx_o),
        .rx_done_o       (rx_done_o),
        .rx_fifo_write_o (rx_fifo_write_o),
        .frame_error_o   (frame_error_o),
        .parity_error_o  (parity_error_o),
        .overrun_error_o (overrun_error_o),
        .busy_o          (busy_o)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
        logic       wr;
        int         idx;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   tick_num = 0;
    int   last_tick_idx = -1;
    int   last_tick_cyc = -1;
    int   done_cnt = 0;
    logic last_wr = 1'b0;
    logic [7:0] h_data = 8'h00;
    logic h_perr = 1'b0, h_ferr = 1'b0, h_ovr = 1'b0;
    logic [1:0] tick_div = 2'd0;

    always #5 clk = ~clk;

    // One ov tick every fourth clock, driven away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            tick_div  = tick_div + 2'd1;
            ov_tick_i = (tick_div == 2'd0);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ov_tick_i) begin
            last_tick_cyc <= cyc + 1;
            last_tick_idx <= tick_num;
            tick_num      <= tick_num + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle, outputs either deliver the next modelled frame or hold
    always @(negedge clk) begin
        if (!rst_n_i) begin
            exp_q.delete();
            h_data = 8'h00; h_perr = 1'b0; h_ferr = 1'b0; h_ovr = 1'b0;
            chk("reset_outputs", 32'({data_rx_o, rx_done_o, rx_fifo_write_o, frame_error_o,
                                      parity_error_o, overrun_error_o, busy_o}), 32'd0);
        end else if (rx_done_o) begin
            done_cnt++;
            last_wr = rx_fifo_write_o;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data", 32'(data_rx_o), 32'(e.data));
                chk("parity_err", 32'(parity_error_o), 32'(e.perr));
                chk("frame_err", 32'(frame_error_o), 32'(e.ferr));
                chk("overrun", 32'(overrun_error_o), 32'(e.ovr));
                chk("fifo_write", 32'(rx_fifo_write_o), 32'(e.wr));
                chk("latency_tick", 32'(last_tick_idx), 32'(e.idx));
                chk("latency_clk", 32'(last_tick_cyc), 32'(cyc));
                h_data = e.data; h_perr = e.perr; h_ferr = e.ferr; h_ovr = e.ovr;
            end
        end else begin
            chk("write_idle", 32'(rx_fifo_write_o), 32'd0);
            chk("data_hold", 32'(data_rx_o), 32'(h_data));
            chk("err_hold", 32'({frame_error_o, parity_error_o, overrun_error_o}),
                32'({h_ferr, h_perr, h_ovr}));
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (ov_tick_i !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    // Drives one frame bit-serially; config_i is scrambled after the start bit to prove latching
    task automatic send_frame(input logic [5:0] cfg, input logic [7:0] data, input logic pbit,
                              input logic stop0, input logic stop1, input logic full,
                              input logic expect_done);
        int   nb, ns, pen;
        logic [7:0] md;
        exp_t x;
        nb  = 5 + int'(cfg[5:4]);
        pen = cfg[3] ? 0 : 1;
        ns  = (cfg[1:0] == 2'b00) ? 1 : 2;
        md  = data & 8'((1 << nb) - 1);
        config_i = cfg;
        rx_fifo_full_i = full;
        wait_ticks(1);
        x.data = md;
        x.perr = (pen == 1) ? (((^md) ^ pbit) != cfg[2]) : 1'b0;
        x.ferr = !stop0 || (ns == 2 && !stop1);
        x.ovr  = full;
        x.wr   = !full;
        x.idx  = tick_num + OS * (1 + nb + pen + ns - 1) + DECIDE;
        if (expect_done) exp_q.push_back(x);
        rx_i = 1'b0;
        wait_ticks(OS);
        config_i = ~cfg;
        for (int i = 0; i < nb; i++) begin
            rx_i = data[i];
            wait_ticks(OS);
        end
        if (pen == 1) begin
            rx_i = pbit;
            wait_ticks(OS);
        end
        rx_i = stop0;
        wait_ticks(OS);
        if (ns == 2) begin
            rx_i = stop1;
            wait_ticks(OS);
        end
        rx_i = 1'b1;
        wait_ticks(OS);
        rx_fifo_full_i = 1'b0;
    endtask

    int d0;

    initial begin
        repeat (5) @(posedge clk);
        #1;
        chk("rst_data", 32'(data_rx_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        rst_n_i = 1'b1;
        wait_ticks(4);

        // Standard frame 0x5A, even parity bit 0
        d0 = done_cnt;
        send_frame(STD_CONFIG, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t1_done_once", 32'(done_cnt - d0), 32'd1);
        chk("t1_data", 32'(data_rx_o), 32'h5A);
        chk("t1_errs", 32'({frame_error_o, parity_error_o, overrun_error_o}), 32'd0);
        chk("t1_write", 32'(last_wr), 32'd1);

        // 5-bit odd parity, 2 stops, wrong parity bit
        send_frame(6'b00_01_01, 8'h13, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t2_data", 32'(data_rx_o), 32'h13);
        chk("t2_perr", 32'(parity_error_o), 32'd1);
        chk("t2_ferr", 32'(frame_error_o), 32'd0);

        // 8-bit no parity, stop driven low, then a clean frame
        send_frame(6'b11_10_00, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t3_data", 32'(data_rx_o), 32'hFF);
        chk("t3_ferr", 32'(frame_error_o), 32'd1);
        send_frame(6'b11_10_00, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t3b_data", 32'(data_rx_o), 32'h01);
        chk("t3b_errs", 32'({frame_error_o, parity_error_o}), 32'd0);

        // Start-bit glitch of 4 ticks
        d0 = done_cnt;
        config_i = STD_CONFIG;
        wait_ticks(1);
        rx_i = 1'b0;
        wait_ticks(4);
        rx_i = 1'b1;
        chk("t4_busy_start", 32'(busy_o), 32'd1);
        wait_ticks(DECIDE - 4);
        chk("t4_busy_pre", 32'(busy_o), 32'd1);
        wait_ticks(1);
        chk("t4_busy_drop", 32'(busy_o), 32'd0);
        wait_ticks(2 * OS);
        chk("t4_no_done", 32'(done_cnt - d0), 32'd0);

        // FIFO full: overrun reported, no write
        send_frame(STD_CONFIG, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t5_data", 32'(data_rx_o), 32'hA5);
        chk("t5_ovr", 32'(overrun_error_o), 32'd1);
        chk("t5_write", 32'(last_wr), 32'd0);

        // Reset mid-frame during data bit 3
        d0 = done_cnt;
        wait_ticks(1);
        rx_i = 1'b0;
        wait_ticks(OS);
        rx_i = 1'b1; wait_ticks(OS);
        rx_i = 1'b0; wait_ticks(OS);
        rx_i = 1'b1; wait_ticks(OS);
        rx_i = 1'b1; wait_ticks(OS / 2);
        rst_n_i = 1'b0;
        #1;
        chk("t6_rst_now", 32'({data_rx_o, overrun_error_o, busy_o, rx_done_o}), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n_i = 1'b1;
        wait_ticks(2 * OS);
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t6_idle", 32'(busy_o), 32'd0);
        send_frame(STD_CONFIG, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t6_data", 32'(data_rx_o), 32'h3C);
        chk("t6_errs", 32'({frame_error_o, parity_error_o, overrun_error_o}), 32'd0);

        // Receiver disabled: whole frame ignored
        d0 = done_cnt;
        rx_enable_i = 1'b0;
        send_frame(STD_CONFIG, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t7_disabled", 32'(done_cnt - d0), 32'd0);
        rx_enable_i = 1'b1;

        // Further widths: 6-bit odd with good parity, 7-bit no parity 2 stops
        send_frame(6'b01_01_00, 8'h2A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t8_data", 32'(data_rx_o), 32'h2A);
        chk("t8_perr", 32'(parity_error_o), 32'd0);
        send_frame(6'b10_11_10, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t9_data", 32'(data_rx_o), 32'h7F);

        wait_ticks(OS);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
